// File: rtl/minaret_bus_pkg.sv
// Shared definitions for the minaret data-memory bus.
// Contents:
//   CONSOLE_ADDR_DEFAULT - default console data/status register address
//   resp_state_e         - responder FSM states (IDLE, WAIT, RESP)
//   region_e             - address decode result (RAM, console, nothing)
//   decode_region()      - maps a byte address onto a region_e
package minaret_bus_pkg;

    localparam logic [31:0] CONSOLE_ADDR_DEFAULT = 32'hffff_ff04;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } resp_state_e;

    typedef enum logic [1:0] {
        REG_RAM     = 2'd0,
        REG_CONSOLE = 2'd1,
        REG_NONE    = 2'd2
    } region_e;

    // RAM takes priority; the console is a single exact address.
    function automatic region_e decode_region(input logic [31:0] addr,
                                              input logic [31:0] ram_bytes,
                                              input logic [31:0] console_addr);
        region_e r;
        if (addr < ram_bytes) begin
            r = REG_RAM;
        end else if (addr == console_addr) begin
            r = REG_CONSOLE;
        end else begin
            r = REG_NONE;
        end
        return r;
    endfunction

endpackage

// File: rtl/console_uart_tx.sv
// Console byte FIFO feeding an 8N1 UART transmitter.
// Ports:
//   clk, resetn      - clock, asynchronous active-low reset
//   push, push_data  - enqueue one byte (dropped only if can_push is low)
//   full             - FIFO holds FIFO_DEPTH bytes
//   can_push         - a push this cycle is stored (not full, or a pop frees a slot)
//   busy             - FIFO non-empty or a frame is on the line
//   uart_tx          - serial line, idle high
module console_uart_tx #(
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       push,
    input  logic [7:0] push_data,
    output logic       full,
    output logic       can_push,
    output logic       busy,
    output logic       uart_tx
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [PW:0]   PTR_ONE  = (PW + 1)'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [7:0]    fifo_q [FIFO_DEPTH];
    logic [PW:0]   wr_ptr_q, wr_ptr_d;
    logic [PW:0]   rd_ptr_q, rd_ptr_d;
    logic          active_q, active_d;
    logic [3:0]    bit_idx_q, bit_idx_d;
    logic [CW-1:0] clk_cnt_q, clk_cnt_d;
    logic [8:0]    shift_q, shift_d;
    logic          tx_q, tx_d;

    logic empty_s, full_s, bit_end_s, frame_end_s, pop_s, push_ok_s;

    assign empty_s     = (wr_ptr_q == rd_ptr_q);
    // Same slot index but different wrap bit means the writer lapped the reader.
    assign full_s      = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                         (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign bit_end_s   = active_q && (clk_cnt_q == CLK_LAST);
    assign frame_end_s = bit_end_s && (bit_idx_q == 4'd9);
    // Popping at the stop-bit boundary makes frames back-to-back with no gap.
    assign pop_s       = !empty_s && (!active_q || frame_end_s);
    assign push_ok_s   = push && (!full_s || pop_s);

    assign full     = full_s;
    assign can_push = !full_s || pop_s;
    assign busy     = active_q || !empty_s;
    assign uart_tx  = tx_q;

    // FIFO storage; no reset needed because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            fifo_q[wr_ptr_q[PW-1:0]] <= push_data;
        end
    end

    // Next-state for pointers and the bit serializer.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        active_d  = active_q;
        bit_idx_d = bit_idx_q;
        clk_cnt_d = clk_cnt_q;
        shift_d   = shift_q;
        tx_d      = tx_q;

        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            // Start bit goes out now; shift holds data LSB-first then the stop bit.
            rd_ptr_d  = rd_ptr_q + PTR_ONE;
            active_d  = 1'b1;
            bit_idx_d = 4'd0;
            clk_cnt_d = {CW{1'b0}};
            shift_d   = {1'b1, fifo_q[rd_ptr_q[PW-1:0]]};
            tx_d      = 1'b0;
        end else if (frame_end_s) begin
            active_d  = 1'b0;
            bit_idx_d = 4'd0;
            clk_cnt_d = {CW{1'b0}};
            tx_d      = 1'b1;
        end else if (bit_end_s) begin
            bit_idx_d = bit_idx_q + 4'd1;
            clk_cnt_d = {CW{1'b0}};
            tx_d      = shift_q[0];
            shift_d   = {1'b1, shift_q[8:1]};
        end else if (active_q) begin
            clk_cnt_d = clk_cnt_q + CNT_ONE;
        end else begin
            tx_d = 1'b1;
        end
    end

    // State registers; reset empties the FIFO and cuts any frame in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q  <= {(PW + 1){1'b0}};
            rd_ptr_q  <= {(PW + 1){1'b0}};
            active_q  <= 1'b0;
            bit_idx_q <= 4'd0;
            clk_cnt_q <= {CW{1'b0}};
            shift_q   <= 9'h1ff;
            tx_q      <= 1'b1;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            active_q  <= active_d;
            bit_idx_q <= bit_idx_d;
            clk_cnt_q <= clk_cnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Slave end of the core's dmem valid/ready bus: word RAM with wait states,
// a console register backed by a UART FIFO, and an error pulse for unmapped
// addresses.
// Ports:
//   clk, resetn                      - clock, asynchronous active-low reset
//   dmem_valid/addr/wmask/wdata      - request (wmask==0 is a read)
//   dmem_ready                       - one-cycle completion pulse
//   dmem_rdata                       - read data, valid with dmem_ready
//   dmem_err                         - unmapped address, pulses with dmem_ready
//   uart_tx                          - console serial line
//   console_busy                     - console FIFO or serializer active
module dmem_responder
    import minaret_bus_pkg::*;
#(
    parameter int unsigned MEM_WORDS    = 4096,
    parameter int unsigned WAIT_STATES  = 1,
    parameter logic [31:0] CONSOLE_ADDR = CONSOLE_ADDR_DEFAULT,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        dmem_valid,
    output logic        dmem_ready,
    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_wmask,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_err,
    output logic        uart_tx,
    output logic        console_busy
);

    localparam int unsigned AW        = $clog2(MEM_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(MEM_WORDS) << 2;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

    logic [31:0] mem [MEM_WORDS];

    resp_state_e state_q, state_d;
    region_e     region_q, region_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [3:0]  wmask_q, wmask_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ready_q, ready_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic ram_we_s, push_s;
    logic fifo_full_s, can_push_s, console_busy_s;
    logic console_stall_s;

    // Only a console write that actually pushes can be held up by a full FIFO.
    assign console_stall_s = (region_q == REG_CONSOLE) && wmask_q[0] && !can_push_s;

    assign dmem_ready   = ready_q;
    assign dmem_rdata   = rdata_q;
    assign dmem_err     = err_q;
    assign console_busy = console_busy_s;

    console_uart_tx #(
        .FIFO_DEPTH   (FIFO_DEPTH),
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_console (
        .clk       (clk),
        .resetn    (resetn),
        .push      (push_s),
        .push_data (wdata_q[7:0]),
        .full      (fifo_full_s),
        .can_push  (can_push_s),
        .busy      (console_busy_s),
        .uart_tx   (uart_tx)
    );

    // RAM byte-lane writes; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask_q[b]) begin
                    mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    // Request FSM: capture in IDLE, count wait states, access, then pulse ready.
    always_comb begin
        state_d  = state_q;
        region_d = region_q;
        idx_d    = idx_q;
        wmask_d  = wmask_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        ready_d  = 1'b0;
        rdata_d  = 32'h0000_0000;
        err_d    = 1'b0;
        ram_we_s = 1'b0;
        push_s   = 1'b0;

        case (state_q)
            IDLE: begin
                if (dmem_valid) begin
                    // The captured copy is what completes, even if valid later drops.
                    state_d  = WAIT;
                    region_d = decode_region(dmem_addr, RAM_BYTES, CONSOLE_ADDR);
                    idx_d    = dmem_addr[AW+1:2];
                    wmask_d  = dmem_wmask;
                    wdata_d  = dmem_wdata;
                    cnt_d    = WAIT_INIT;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (console_stall_s) begin
                    state_d = WAIT;
                end else begin
                    state_d = RESP;
                    ready_d = 1'b1;
                    case (region_q)
                        REG_RAM: begin
                            if (wmask_q == 4'b0000) begin
                                rdata_d = mem[idx_q];
                            end else begin
                                ram_we_s = 1'b1;
                            end
                        end
                        REG_CONSOLE: begin
                            if (wmask_q == 4'b0000) begin
                                rdata_d = {30'd0, console_busy_s, fifo_full_s};
                            end else begin
                                push_s = wmask_q[0];
                            end
                        end
                        REG_NONE: begin
                            err_d = 1'b1;
                        end
                        default: begin
                            err_d = 1'b1;
                        end
                    endcase
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM, capture and output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            region_q <= REG_NONE;
            idx_q    <= {AW{1'b0}};
            wmask_q  <= 4'b0000;
            wdata_q  <= 32'h0000_0000;
            cnt_q    <= 4'd0;
            ready_q  <= 1'b0;
            rdata_q  <= 32'h0000_0000;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            region_q <= region_d;
            idx_q    <= idx_d;
            wmask_q  <= wmask_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    localparam int          W    = 1;
    localparam int          CPB  = 4;
    localparam int          DEP  = 8;
    localparam int          MEMW = 4096;
    localparam logic [31:0] CON  = 32'hffff_ff04;
    localparam int          NLAT = W + 2;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        dmem_valid = 1'b0;
    logic [31:0] dmem_addr = 32'h0;
    logic [3:0]  dmem_wmask = 4'h0;
    logic [31:0] dmem_wdata = 32'h0;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        dmem_err;
    logic        uart_tx;
    logic        console_busy;

    dmem_responder #(
        .MEM_WORDS    (MEMW),
        .WAIT_STATES  (W),
        .CONSOLE_ADDR (CON),
        .FIFO_DEPTH   (DEP),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .dmem_valid   (dmem_valid),
        .dmem_ready   (dmem_ready),
        .dmem_addr    (dmem_addr),
        .dmem_wmask   (dmem_wmask),
        .dmem_wdata   (dmem_wdata),
        .dmem_rdata   (dmem_rdata),
        .dmem_err     (dmem_err),
        .uart_tx      (uart_tx),
        .console_busy (console_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        bit          chk_rd;
    } exp_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    exp_t        sb_q[$];
    logic [7:0]  uart_q[$];
    logic [31:0] ref_mem [int];
    logic [31:0] addrs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Issue one request; expected response goes to the scoreboard first.
    task automatic req(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d,
                       input logic [31:0] er, input logic ee, input bit chk_rd,
                       input int exp_lat, input bit short_valid);
        bit got;
        int lat;
        exp_t e;
        e.rdata = er; e.err = ee; e.chk_rd = chk_rd;
        sb_q.push_back(e);
        dmem_addr = a; dmem_wmask = m; dmem_wdata = d; dmem_valid = 1'b1;
        got = 1'b0;
        lat = -1;
        for (int c = 0; c < 400 && !got; c++) begin
            @(negedge clk);
            if (short_valid && c == 1) begin
                dmem_valid = 1'b0;
                dmem_addr  = 32'hffff_0000;
                dmem_wdata = 32'h5555_5555;
            end
            if (dmem_ready) begin
                got = 1'b1;
                lat = c;
            end
        end
        if (!got) begin
            check("req_timeout", 32'd0, 32'd1);
        end else if (exp_lat >= 0) begin
            check("latency", lat, exp_lat);
        end else begin
            n_cmp = n_cmp;
        end
        sync();
        dmem_valid = 1'b0;
    endtask

    task automatic ram_write(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d, input bit short_valid);
        logic [31:0] w;
        w = ref_mem.exists(int'(a >> 2)) ? ref_mem[int'(a >> 2)] : 32'h0;
        for (int b = 0; b < 4; b++) if (m[b]) w[8*b +: 8] = d[8*b +: 8];
        ref_mem[int'(a >> 2)] = w;
        req(a, m, d, 32'h0, 1'b0, 1'b0, NLAT, short_valid);
    endtask

    task automatic ram_read(input logic [31:0] a);
        req(a, 4'h0, 32'h0, ref_mem[int'(a >> 2)], 1'b0, 1'b1, NLAT, 1'b0);
    endtask

    task automatic con_write(input logic [7:0] b, input logic [3:0] m, input int lat);
        if (m[0]) uart_q.push_back(b);
        req(CON, m, {24'h0, b}, 32'h0, 1'b0, 1'b0, lat, 1'b0);
    endtask

    task automatic wait_not_busy(input int limit, output int cyc);
        cyc = -1;
        for (int c = 0; c < limit; c++) begin
            @(negedge clk);
            if (!console_busy) begin
                cyc = c;
                break;
            end
        end
    endtask

    // Response monitor: pops the scoreboard whenever ready is seen.
    initial begin : resp_mon
        exp_t e;
        forever begin
            @(negedge clk);
            if (resetn) begin
                if (dmem_ready) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_ready", 32'd1, 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        if (e.chk_rd) check("rdata", dmem_rdata, e.rdata);
                        check("err", {31'd0, dmem_err}, {31'd0, e.err});
                    end
                end else begin
                    check("err_without_ready", {31'd0, dmem_err}, 32'd0);
                end
            end
        end
    end

    // Line monitor: decodes 8N1 frames at mid-bit and checks them in order.
    initial begin : uart_mon
        int pos;
        logic [7:0] rx;
        pos = -1;
        rx = 8'h00;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                pos = -1;
            end else begin
                if (pos < 0 && uart_tx === 1'b0) pos = 0;
                else if (pos >= 0) pos = pos + 1;
                if (pos >= 0) begin
                    if (pos == CPB / 2) begin
                        check("start_bit", {31'd0, uart_tx}, 32'd0);
                    end else if (pos % CPB == CPB / 2 && pos / CPB >= 1 && pos / CPB <= 8) begin
                        rx[pos / CPB - 1] = uart_tx;
                    end else if (pos == 9 * CPB + CPB / 2) begin
                        check("stop_bit", {31'd0, uart_tx}, 32'd1);
                        check("busy_in_frame", {31'd0, console_busy}, 32'd1);
                        if (uart_q.size() == 0) check("unexpected_byte", {24'd0, rx}, 32'hffff_ffff);
                        else check("uart_byte", {24'd0, rx}, {24'd0, uart_q.pop_front()});
                    end
                    if (pos == 10 * CPB - 1) pos = -1;
                end
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int cyc;
        logic [31:0] a;
        logic [3:0] m;
        int kind;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, dmem_ready}, 32'd0);
        check("rst_rdata", dmem_rdata, 32'd0);
        check("rst_err", {31'd0, dmem_err}, 32'd0);
        check("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
        check("rst_busy", {31'd0, console_busy}, 32'd0);
        resetn = 1'b1;
        sync();

        // Full-word write and read back, then a single-lane write.
        ram_write(32'h10, 4'b1111, 32'hDEAD_BEEF, 1'b0);
        ram_read(32'h10);
        ram_write(32'h10, 4'b0100, 32'h00AA_0000, 1'b0);
        ram_read(32'h10);
        check("model_byte_lane", ref_mem[4], 32'hDEAA_BEEF);

        // Unmapped read and write; word 0 must be untouched by the aliasing write.
        ram_write(32'h0, 4'b1111, 32'hCAFE_F00D, 1'b0);
        req(32'h8000_0000, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1, NLAT, 1'b0);
        req(32'hffff_0000, 4'hf, 32'h1234, 32'h0, 1'b1, 1'b0, NLAT, 1'b0);
        ram_read(32'h0);

        // Valid dropped before ready: the captured write still lands.
        ram_write(32'h20, 4'b1111, 32'h0BAD_F00D, 1'b1);
        ram_read(32'h20);

        // Single console byte: frame lasts 10*CPB cycles after the pop.
        con_write(8'h48, 4'b0001, NLAT);
        wait_not_busy(200, cyc);
        check("busy_duration", cyc, 10 * CPB);
        check("line_idle_after", {31'd0, uart_tx}, 32'd1);
        sync();

        // Fill the FIFO behind a running frame; the tenth write stalls.
        for (int i = 0; i < 9; i++) con_write(8'h30 + 8'(i), 4'b0001, NLAT);
        req(CON, 4'h0, 32'h0, 32'h3, 1'b0, 1'b1, NLAT, 1'b0);
        con_write(8'h39, 4'b0001, NLAT + 1);
        wait_not_busy(1000, cyc);
        check("drain_fill", {31'd0, cyc < 0}, 32'd0);
        check("fill_bytes_left", uart_q.size(), 32'd0);
        sync();

        // Console write without lane 0 completes and sends nothing.
        con_write(8'h77, 4'b1110, NLAT);
        check("no_push_busy", {31'd0, console_busy}, 32'd0);

        // Reset mid-frame with three bytes queued.
        con_write(8'h00, 4'b0001, NLAT);
        con_write(8'h11, 4'b0001, NLAT);
        con_write(8'h22, 4'b0001, NLAT);
        con_write(8'h33, 4'b0001, NLAT);
        check("pre_reset_line", {31'd0, uart_tx}, 32'd0);
        resetn = 1'b0;
        uart_q.delete();
        #1;
        check("reset_uart_tx", {31'd0, uart_tx}, 32'd1);
        check("reset_ready", {31'd0, dmem_ready}, 32'd0);
        check("reset_busy", {31'd0, console_busy}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        sync();
        req(CON, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, NLAT, 1'b0);
        ram_read(32'h10);
        repeat (60) @(posedge clk);
        #1;
        check("post_reset_idle", {31'd0, console_busy}, 32'd0);

        // Randomized mix against the reference model.
        for (int i = 0; i < 16; i++) begin
            addrs[i] = {18'd0, 12'($urandom_range(0, MEMW - 1)), 2'b00};
            ram_write(addrs[i], 4'b1111, $urandom, 1'b0);
        end
        for (int i = 0; i < 150; i++) begin
            kind = $urandom_range(0, 9);
            a = addrs[$urandom_range(0, 15)];
            if (kind <= 3) begin
                m = 4'($urandom_range(1, 15));
                ram_write(a, m, $urandom, 1'b0);
            end else if (kind <= 6) begin
                ram_read(a);
            end else if (kind == 7) begin
                a = 32'h0001_0000 | ($urandom & 32'h7fff_fffc);
                if ($urandom_range(0, 1) == 0) req(a, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1, NLAT, 1'b0);
                else req(a, 4'hf, $urandom, 32'h0, 1'b1, 1'b0, NLAT, 1'b0);
            end else if (kind == 8) begin
                con_write(8'($urandom), 4'($urandom_range(0, 15)), -1);
            end else begin
                ram_write(a, 4'($urandom_range(1, 15)), $urandom, 1'b1);
            end
        end
        for (int i = 0; i < 16; i++) ram_read(addrs[i]);

        wait_not_busy(5000, cyc);
        check("final_drain", {31'd0, cyc < 0}, 32'd0);
        repeat (4) @(negedge clk);
        check("uart_queue_empty", uart_q.size(), 32'd0);
        check("scoreboard_empty", sb_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Synthesizable data-memory responder: the slave end of the core's dmem valid/ready/addr/wmask/wdata/rdata interface.
- Serves a word-organised on-chip RAM with a configurable wait-state count.
- Maps the console address to a byte FIFO that drains through an 8N1 UART transmitter.
- Sits between the minaret core and its FPGA top level, in place of the simulation memory model.

Parameters:
- MEM_WORDS, 4096: RAM depth in 32-bit words; power of two.
- WAIT_STATES, 1: extra cycles between request capture and the ready pulse; range 0..15.
- CONSOLE_ADDR, 32'hffffff04: console data/status register address.
- FIFO_DEPTH, 8: console FIFO entries; power of two, at least 2.
- CLKS_PER_BIT, 868: UART bit period in clk cycles; at least 2.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- resetn  input  1  reset; asynchronous assert, active-low.
- dmem_valid  input  1  request valid; held with addr/wmask/wdata until ready is seen.
- dmem_ready  output  1  one-cycle completion pulse.
- dmem_addr  input  32  byte address; bits [1:0] ignored (word access).
- dmem_wmask  input  4  byte-lane write enables; 0 means read.
- dmem_wdata  input  32  write data.
- dmem_rdata  output  32  read data; valid only while dmem_ready=1.
- dmem_err  output  1  pulses with dmem_ready when the address decodes to nothing.
- uart_tx  output  1  serial console line; idle high.
- console_busy  output  1  high when the FIFO is non-empty or the serializer is active.

Behaviour:
- Reset (resetn=0, asynchronous):
  - dmem_ready=0, dmem_rdata=0, dmem_err=0, uart_tx=1, console_busy=0.
  - FIFO is emptied; FSM goes to IDLE; wait counter is cleared.
  - RAM contents are not reset; they are preserved across reset.
  - Reset mid-frame cuts the frame immediately and drops all queued bytes.
- Address decode:
  - RAM when addr < MEM_WORDS*4; word index is addr[log2(MEM_WORDS)+1:2].
  - CONSOLE when addr == CONSOLE_ADDR.
  - Anything else is NONE.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: on dmem_valid=1, register addr/wmask/wdata and the decode result, load the counter with WAIT_STATES, go to WAIT. dmem_ready=0.
  - WAIT: decrement the counter. When it is 0 and no console stall is pending, perform the access and go to RESP.
    - RAM read: registered synchronous read.
    - RAM write: byte lanes per wmask.
    - Console write: push wdata[7:0] when wmask[0]=1.
  - RESP: dmem_ready=1 for exactly one cycle with dmem_rdata valid, then go to IDLE. dmem_rdata returns to 0 in IDLE.
- Latency: valid sampled at edge N gives dmem_ready high during the cycle after edge N+WAIT_STATES+1. Minimum request spacing is WAIT_STATES+3 cycles, because IDLE always occupies one cycle.
- Console stall: a console write with the FIFO full holds in WAIT, ready withheld, until a pop frees an entry. Push and pop in the same cycle on a full FIFO is allowed; the push completes.
- Console read: rdata = {30'b0, console_busy, fifo_full}; no side effects.
- NONE: reads return 0, writes are dropped, dmem_err=1 in the RESP cycle.
- wmask bits other than [0] are ignored for console writes. A console write with wmask[0]=0 is a no-op that still completes normally.
- Protocol violation: if dmem_valid drops before ready, the captured transaction still completes, including any write; the ready pulse is still issued.
- UART serializer:
  - When idle and the FIFO is non-empty, pop one byte (one cycle after the push at the earliest).
  - Frame: start bit 0, then data bits 0..7 LSB first, then stop bit 1. Each bit lasts CLKS_PER_BIT cycles, 10 bits total.
  - The next frame may start in the cycle after the stop bit ends; there is no extra idle gap.
- FIFO: circular, with log2(FIFO_DEPTH)+1-bit pointers. Full and empty are distinguished by the wrap bit; pointers wrap cleanly.

Decomposition:
- Package minaret_bus_pkg:
  - CONSOLE_ADDR default;
  - responder state enum {IDLE, WAIT, RESP};
  - region enum {REG_RAM, REG_CONSOLE, REG_NONE}.
- One sub-module, console_uart_tx, containing the FIFO and serializer.
  - Inputs: push, push_data.
  - Outputs: full, busy, uart_tx.
  - Parameters: FIFO_DEPTH, CLKS_PER_BIT.
- RAM is inferred inside dmem_responder.

Test Plan:
1. Write 0xDEADBEEF (wmask 4'b1111) to 0x10, then read 0x10. With WAIT_STATES=1: each ready pulses once, 3 cycles after valid is sampled; read rdata=0xDEADBEEF, dmem_err=0.
2. Write 0x00AA0000 (wmask 4'b0100) to 0x10, then read. Expect rdata=0xDEAABEEF; other bytes untouched.
3. CLKS_PER_BIT=4, console write 0x48. Expect uart_tx = 0 for 4 cycles, then bits 0,0,0,1,0,0,1,0 for 4 cycles each, then 1 for 4 cycles. console_busy is high throughout and low afterwards.
4. FIFO_DEPTH=8, CLKS_PER_BIT=4, 10 back-to-back console writes. Expect writes 1-9 to complete at normal latency. Write 10 stalls until the first frame ends (40 cycles after its start bit begins); all 10 bytes appear on the line in order.
5. Read 0x8000_0000 and write 0x1234 to 0xffff0000. Expect rdata=0 and dmem_err pulsed with ready on both; RAM word 0 unchanged.
6. Assert resetn low mid-frame with 3 bytes queued. Expect uart_tx=1 and dmem_ready=0 immediately. After release, a console read returns 0 and a RAM word written before reset still reads back unchanged.
